line_vec_gen: RTL and testbench

//  Producer side of the column-vector interface into the sliding-window generator.

---
 rtl/line_vec_gen_if.sv | 24 ++
 rtl/line_vec_gen.sv | 110 +++++++++++
 tb/tb_line_vec_gen.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/line_vec_gen_if.sv
// Handshake bundle between pixel source, line_vec_gen and the column-vector consumer.
interface line_vec_gen_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int VECTOR_SIZE = 3
);
  logic                              pix_valid_i;
  logic [DATA_WIDTH-1:0]             pix_data_i;
  logic                              pix_ready_o;
  logic                              vector_valid_o;
  logic                              vector_ready_i;
  logic [VECTOR_SIZE*DATA_WIDTH-1:0] vector_data_o;
  logic                              vector_sol_o;
  logic                              vector_eof_o;

  modport master (
    output pix_valid_i, pix_data_i, vector_ready_i,
    input  pix_ready_o, vector_valid_o, vector_data_o, vector_sol_o, vector_eof_o
  );

  modport slave (
    input  pix_valid_i, pix_data_i, vector_ready_i,
    output pix_ready_o, vector_valid_o, vector_data_o, vector_sol_o, vector_eof_o
  );
endinterface

// File: rtl/line_vec_gen.sv
// Buffers VECTOR_SIZE-1 raster lines and emits one column vector per accepted pixel
// once enough rows are present; slice 0 is the newest row.
module line_vec_gen #(
  parameter int DATA_WIDTH  = 8,
  parameter int VECTOR_SIZE = 3,
  parameter int IMG_WIDTH   = 32,
  parameter int IMG_HEIGHT  = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  line_vec_gen_if.slave  vif
);
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int VW = VECTOR_SIZE * DATA_WIDTH;

  logic [CW-1:0]         col_cnt_r;
  logic [RW-1:0]         row_cnt_r;
  logic [DATA_WIDTH-1:0] line_buf_r [VECTOR_SIZE-1][IMG_WIDTH];

  logic          vec_valid_r;
  logic [VW-1:0] vec_data_r;
  logic          vec_sol_r;
  logic          vec_eof_r;

  logic          pix_ready_s;
  logic          accept_s;
  logic          col_last_s;
  logic          row_last_s;
  logic          emit_s;
  logic [VW-1:0] vec_pack_s;

  assign pix_ready_s = !rst && (!vec_valid_r || vif.vector_ready_i);
  // clear wins over traffic: a pixel offered during clear is dropped
  assign accept_s    = vif.pix_valid_i && pix_ready_s && !clear;
  assign col_last_s  = (col_cnt_r == CW'(IMG_WIDTH - 1));
  assign row_last_s  = (row_cnt_r == RW'(IMG_HEIGHT - 1));
  assign emit_s      = (row_cnt_r >= RW'(VECTOR_SIZE - 1));

  // Column vector assembled from the incoming pixel and the buffered lines
  always_comb begin
    vec_pack_s = '0;
    vec_pack_s[DATA_WIDTH-1:0] = vif.pix_data_i;
    for (int j = 1; j < VECTOR_SIZE; j++) begin
      vec_pack_s[j*DATA_WIDTH +: DATA_WIDTH] = line_buf_r[j-1][col_cnt_r];
    end
  end

  // Line buffer shift at the current column; contents need no reset
  always_ff @(posedge clk) begin
    if (accept_s) begin
      line_buf_r[0][col_cnt_r] <= vif.pix_data_i;
      for (int k = 1; k < VECTOR_SIZE - 1; k++) begin
        line_buf_r[k][col_cnt_r] <= line_buf_r[k-1][col_cnt_r];
      end
    end
  end

  // Raster position counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt_r <= '0;
      row_cnt_r <= '0;
    end else if (clear) begin
      col_cnt_r <= '0;
      row_cnt_r <= '0;
    end else if (accept_s) begin
      if (col_last_s) begin
        col_cnt_r <= '0;
        row_cnt_r <= row_last_s ? '0 : row_cnt_r + RW'(1);
      end else begin
        col_cnt_r <= col_cnt_r + CW'(1);
      end
    end
  end

  // Single-entry output register; reloads on the drain edge for full throughput
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_valid_r <= 1'b0;
      vec_data_r  <= '0;
      vec_sol_r   <= 1'b0;
      vec_eof_r   <= 1'b0;
    end else if (clear) begin
      vec_valid_r <= 1'b0;
      vec_sol_r   <= 1'b0;
      vec_eof_r   <= 1'b0;
    end else if (accept_s) begin
      if (emit_s) begin
        vec_valid_r <= 1'b1;
        vec_data_r  <= vec_pack_s;
        vec_sol_r   <= (col_cnt_r == CW'(0));
        vec_eof_r   <= col_last_s && row_last_s;
      end else begin
        vec_valid_r <= 1'b0;
        vec_sol_r   <= 1'b0;
        vec_eof_r   <= 1'b0;
      end
    end else if (vif.vector_ready_i) begin
      vec_valid_r <= 1'b0;
    end
  end

  assign vif.pix_ready_o    = pix_ready_s;
  assign vif.vector_valid_o = vec_valid_r;
  assign vif.vector_data_o  = vec_data_r;
  assign vif.vector_sol_o   = vec_sol_r;
  assign vif.vector_eof_o   = vec_eof_r;
endmodule

// File: tb/tb_line_vec_gen.sv
// Directed bench for line_vec_gen on a 4x4 frame, kernel height 3, pixel = base + row*16 + col.
module tb_line_vec_gen;
  logic clk;
  logic rst;
  logic clear;
  int   errors;
  int   checks;
  logic [25:0] obs_q [$];

  line_vec_gen_if #(.DATA_WIDTH(8), .VECTOR_SIZE(3)) vif ();

  line_vec_gen #(
    .DATA_WIDTH(8), .VECTOR_SIZE(3), .IMG_WIDTH(4), .IMG_HEIGHT(4)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear), .vif(vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: continuous; 1: consumer stall of 5 clk at row 2 col 2; 2: bubbles on both sides
  task automatic stream(input int npix, input int mode, input logic [7:0] base);
    int p = 0;
    int cyc = 0;
    int hold = 0;
    int q;
    logic [23:0] held = '0;
    logic prev_emit = 1'b0;
    logic acc;
    logic vr;
    logic pv;
    while (p < npix && cyc < 400) begin
      q  = p % 16;
      pv = (mode == 2) ? ((cyc % 3) != 1) : 1'b1;
      if (mode == 1) vr = !(p >= 10 && hold < 5);
      else if (mode == 2) vr = ((cyc % 4) != 2);
      else vr = 1'b1;
      vif.pix_valid_i    = pv;
      vif.pix_data_i     = base + 8'((q / 4) * 16 + (q % 4));
      vif.vector_ready_i = vr;
      @(negedge clk);
      if (mode == 0) chk("latency_valid", {31'd0, vif.vector_valid_o}, {31'd0, prev_emit});
      if (mode == 1 && !vr) begin
        chk("stall_pix_ready", {31'd0, vif.pix_ready_o}, 32'd0);
        chk("stall_valid", {31'd0, vif.vector_valid_o}, 32'd1);
        if (hold == 0) held = vif.vector_data_o;
        else chk("stall_data_stable", {8'd0, vif.vector_data_o}, {8'd0, held});
        hold++;
      end
      if (vif.vector_valid_o && vr)
        obs_q.push_back({vif.vector_eof_o, vif.vector_sol_o, vif.vector_data_o});
      acc = pv && vif.pix_ready_o && !clear;
      prev_emit = acc && ((q / 4) >= 2);
      if (acc) p++;
      @(posedge clk); #1;
      cyc++;
    end
    if (p < npix) chk("stream_timeout", p, npix);
  endtask

  task automatic drain();
    vif.pix_valid_i    = 1'b0;
    vif.vector_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (vif.vector_valid_o)
        obs_q.push_back({vif.vector_eof_o, vif.vector_sol_o, vif.vector_data_o});
      @(posedge clk); #1;
    end
  endtask

  task automatic check_frames(input string tag, input int nframes, input logic [7:0] base);
    int k, r, c, eofs;
    logic [25:0] exp;
    eofs = 0;
    chk({tag, "_count"}, obs_q.size(), 8 * nframes);
    for (int i = 0; i < obs_q.size() && i < 8 * nframes; i++) begin
      k = i % 8;
      r = k / 4 + 2;
      c = k % 4;
      exp = {(k == 7), (c == 0),
             base + 8'((r - 2) * 16 + c), base + 8'((r - 1) * 16 + c), base + 8'(r * 16 + c)};
      chk($sformatf("%s_vec%0d", tag, i), {6'd0, obs_q[i]}, {6'd0, exp});
      if (obs_q[i][25]) eofs++;
    end
    chk({tag, "_eof_count"}, eofs, nframes);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    clear = 1'b0;
    vif.pix_valid_i = 1'b0;
    vif.pix_data_i = 8'd0;
    vif.vector_ready_i = 1'b0;
    #1;
    chk("rst_pix_ready", {31'd0, vif.pix_ready_o}, 32'd0);
    chk("rst_valid", {31'd0, vif.vector_valid_o}, 32'd0);
    chk("rst_data", {8'd0, vif.vector_data_o}, 32'd0);
    chk("rst_sol", {31'd0, vif.vector_sol_o}, 32'd0);
    chk("rst_eof", {31'd0, vif.vector_eof_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // continuous frame
    obs_q.delete();
    stream(16, 0, 8'h00);
    drain();
    check_frames("t1", 1, 8'h00);

    // consumer stall mid-row 2
    obs_q.delete();
    stream(16, 1, 8'h00);
    drain();
    check_frames("t2", 1, 8'h00);

    // bubbles on both handshakes
    obs_q.delete();
    stream(16, 2, 8'h00);
    drain();
    check_frames("t3", 1, 8'h00);

    // clear while row 2 col 1 is offered
    stream(9, 0, 8'h00);
    clear = 1'b1;
    vif.pix_valid_i = 1'b1;
    vif.pix_data_i = 8'h21;
    vif.vector_ready_i = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clear_valid", {31'd0, vif.vector_valid_o}, 32'd0);
    chk("clear_sol", {31'd0, vif.vector_sol_o}, 32'd0);
    chk("clear_eof", {31'd0, vif.vector_eof_o}, 32'd0);
    obs_q.delete();
    stream(16, 0, 8'h40);
    drain();
    check_frames("t4", 1, 8'h40);

    // reset pulse mid-row 3
    stream(13, 0, 8'h00);
    rst = 1'b1;
    #1;
    chk("midrst_pix_ready", {31'd0, vif.pix_ready_o}, 32'd0);
    chk("midrst_valid", {31'd0, vif.vector_valid_o}, 32'd0);
    chk("midrst_data", {8'd0, vif.vector_data_o}, 32'd0);
    chk("midrst_sol", {31'd0, vif.vector_sol_o}, 32'd0);
    chk("midrst_eof", {31'd0, vif.vector_eof_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    obs_q.delete();
    stream(16, 0, 8'h00);
    drain();
    check_frames("t5", 1, 8'h00);

    // two frames back-to-back
    obs_q.delete();
    stream(32, 0, 8'h00);
    drain();
    check_frames("t6", 2, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
